// File: rtl/crossbar_read_scheduler.sv
// crossbar_read_scheduler
//   Sequences one batch of four word-addressed reads onto a 4-bank,
//   low-order-interleaved scratchpad. Bank = addr[1:0], in-bank address =
//   addr[ADDRW-1:2]. Requests that collide on a bank are replayed over
//   successive cycles with fixed priority 0>1>2>3. The four results are
//   returned together with a single done pulse.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   start, addr0..addr3     : batch launch and requester word addresses
//   busy                    : batch in progress (state != IDLE)
//   done                    : one-cycle pulse, rdata0..3 valid
//   rdata0..rdata3          : returned words (registered, hold otherwise)
//   bank_en0..3/bank_addr0..3 : per-bank read enable / in-bank address
//   bank_q0..bank_q3        : bank read data, valid the cycle after bank_en
module crossbar_read_scheduler #(
  parameter int ADDRW = 10,
  parameter int WL    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] addr0,
  input  logic [ADDRW-1:0] addr1,
  input  logic [ADDRW-1:0] addr2,
  input  logic [ADDRW-1:0] addr3,
  output logic             busy,
  output logic             done,
  output logic [WL-1:0]    rdata0,
  output logic [WL-1:0]    rdata1,
  output logic [WL-1:0]    rdata2,
  output logic [WL-1:0]    rdata3,
  output logic             bank_en0,
  output logic             bank_en1,
  output logic             bank_en2,
  output logic             bank_en3,
  output logic [ADDRW-3:0] bank_addr0,
  output logic [ADDRW-3:0] bank_addr1,
  output logic [ADDRW-3:0] bank_addr2,
  output logic [ADDRW-3:0] bank_addr3,
  input  logic [WL-1:0]    bank_q0,
  input  logic [WL-1:0]    bank_q1,
  input  logic [WL-1:0]    bank_q2,
  input  logic [WL-1:0]    bank_q3
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] addr_in    [4];
  logic [ADDRW-1:0] addr_q     [4];
  logic [WL-1:0]    bank_q_arr [4];
  logic [WL-1:0]    rdata_q    [4];
  logic [1:0]       cap_bank_q [4];
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       cap_valid_q, cap_valid_d;
  logic [3:0]       grant;
  logic [3:0]       bank_en_c;
  logic [ADDRW-3:0] bank_addr_c [4];
  logic             done_q, done_d;
  logic             load;

  assign addr_in[0] = addr0;
  assign addr_in[1] = addr1;
  assign addr_in[2] = addr2;
  assign addr_in[3] = addr3;

  assign bank_q_arr[0] = bank_q0;
  assign bank_q_arr[1] = bank_q1;
  assign bank_q_arr[2] = bank_q2;
  assign bank_q_arr[3] = bank_q3;

  // Arbitration: walk requesters in priority order; the first pending
  // requester that finds its bank still free claims it. Identical addresses
  // are not merged, so the second one simply loses and retries next round.
  always_comb begin
    grant     = '0;
    bank_en_c = '0;
    for (int b = 0; b < 4; b++) bank_addr_c[b] = '0;
    if (state_q == S_ISSUE) begin
      for (int r = 0; r < 4; r++) begin
        if (pending_q[r] && !bank_en_c[addr_q[r][1:0]]) begin
          bank_en_c[addr_q[r][1:0]]   = 1'b1;
          bank_addr_c[addr_q[r][1:0]] = addr_q[r][ADDRW-1:2];
          grant[r]                    = 1'b1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    cap_valid_d = '0;
    done_d      = 1'b0;
    load        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          pending_d = 4'b1111;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pending_d   = pending_q & ~grant;
        cap_valid_d = grant;
        if (pending_d == 4'b0000) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Final round's data is captured this cycle; done lines up with it.
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      cap_valid_q <= '0;
      done_q      <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        addr_q[r]     <= '0;
        cap_bank_q[r] <= '0;
        rdata_q[r]    <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      cap_valid_q <= cap_valid_d;
      done_q      <= done_d;
      for (int r = 0; r < 4; r++) begin
        if (load)           addr_q[r]     <= addr_in[r];
        if (grant[r])       cap_bank_q[r] <= addr_q[r][1:0];
        // Bank data arrives one cycle after the grant; pick it from the
        // bank this requester was granted on.
        if (cap_valid_q[r]) rdata_q[r]    <= bank_q_arr[cap_bank_q[r]];
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];
  assign rdata2 = rdata_q[2];
  assign rdata3 = rdata_q[3];

  assign bank_en0 = bank_en_c[0];
  assign bank_en1 = bank_en_c[1];
  assign bank_en2 = bank_en_c[2];
  assign bank_en3 = bank_en_c[3];

  assign bank_addr0 = bank_addr_c[0];
  assign bank_addr1 = bank_addr_c[1];
  assign bank_addr2 = bank_addr_c[2];
  assign bank_addr3 = bank_addr_c[3];

endmodule

// File: doc/crossbar_read_scheduler.md
# crossbar_read_scheduler

Sequencer that turns one batch of four word-addressed read requests into conflict-free accesses on the 4-bank, low-order-interleaved scratchpad behind the 4x4 crossbar. Bank select is `addr[1:0]` and the in-bank address is `addr[ADDRW-1:2]`. Requests that collide on a bank are replayed over successive cycles. Results are captured per requester, and all four words are returned together with a single `done` pulse, so the upstream PE never handles stalls.

## Interface
- `ADDRW`, 10, word address width (2 bank bits + `ADDRW-2` in-bank bits)
- `WL`, 32, data word width
- `clk` in 1: sole clock; all state updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: launch a batch; sampled only when `busy`=0
- `addr0`..`addr3` in ADDRW: requester word addresses, sampled with `start`
- `busy` out 1: batch in progress
- `done` out 1: one-cycle pulse; `rdata0..3` valid in this cycle
- `rdata0`..`rdata3` out WL: returned words, registered
- `bank_en0`..`bank_en3` out 1: read enable to bank b
- `bank_addr0`..`bank_addr3` out ADDRW-2: in-bank address to bank b; 0 when `bank_en`=0
- `bank_q0`..`bank_q3` in WL: bank read data, valid the cycle after `bank_en`

## Operation
- **States:**
  - IDLE
  - ISSUE
  - DRAIN
- **IDLE → ISSUE on `start`:**
  - Latch `addr0..3`.
  - Set `pending`=4'b1111.
- **Arbitration in ISSUE, per bank b:**
  - Grant the lowest-index requester r with `pending[r]`=1 and `addr_r[1:0]`=b.
  - Drive `bank_en_b`=1 and `bank_addr_b`=`addr_r[ADDRW-1:2]`.
  - Fixed priority 0>1>2>3, matching the crossbar stall priority.
- **Grant bookkeeping:**
  - Granted requesters clear their `pending` bit at the clock edge.
  - Register a one-cycle `cap_valid[r]` plus bank index `cap_bank[r]`.
- **Capture:**
  - When `cap_valid[r]`=1, `rdata_r` <= `bank_q[cap_bank[r]]`.
  - Capture runs in both ISSUE and DRAIN.
- **ISSUE → DRAIN:** when the post-grant `pending` is 0.
- **DRAIN → IDLE:**
  - Capture the final round.
  - Assert `done` (registered) for the next cycle.
- **Identical addresses** from two requesters are still serialized; no merging.
- **Round count:** k = maximum number of requests targeting any single bank, 1..4.
- **`start` while `busy`=1:** ignored; the latched addresses are unchanged.
- **`rdata` outside `done`:** holds its last value. During a batch a register may update mid-batch, so it is valid only when `done`=1.

## Timing
- **Cycle numbering:** `start`=1 and `busy`=0 in cycle 0.
  - Cycles 1..k: ISSUE, `bank_en` active.
  - Cycle k+1: DRAIN.
  - Cycle k+2: `done`=1 and `busy`=0.
  - Latency is k+2 cycles, from 3 (no conflicts) to 6 (all four on one bank).
- **`busy`:** 1 in cycles 1..k+1; combinational from state (not IDLE).
- **Back-to-back batches:** a new `start` is accepted in the `done` cycle. That batch's ISSUE begins the next cycle, so sustained throughput is one batch per k+2 cycles.
- **`bank_en` / `bank_addr`:** combinational from state, `pending` and latched addresses. All 0 outside ISSUE.
- **Reset (including mid-batch):** at the edge with `rst`=1:
  - State → IDLE.
  - `pending`, `cap_valid` and `done` → 0.
  - `rdata0..3` → 0.
  - Consequently `busy`=0 and all `bank_en`=0 from the next cycle.
  - No `done` is produced for an aborted batch.
  - `rst` overrides a simultaneous `start`.

## Test plan
Bank model: 1-cycle registered read returning `b*256 + in_bank_addr`.

- **No conflicts:** `addr`={0x010,0x021,0x032,0x043} → one round with all four `bank_en` in cycle 1; `done` in cycle 3; `rdata`={0x004,0x108,0x20C,0x310}.
- **Full conflict:** `addr`={0x004,0x008,0x00C,0x010}, all bank 0 → `bank_en0` for cycles 1–4 with `bank_addr0`=1,2,3,4 in order; `done` in cycle 6; `rdata`={1,2,3,4}.
- **2+2 split:** `addr`={0x001,0x005,0x002,0x006} → cycle 1 grants r0 (bank1) and r2 (bank2); cycle 2 grants r1 and r3; `done` in cycle 4; `rdata`={0x100,0x101,0x200,0x201}.
- **Start while busy:** second `start` with different addresses in cycle 2 of the full-conflict batch → ignored; results are identical to the full-conflict case; exactly one `done`.
- **Reset mid-batch:** `rst`=1 in cycle 2 of the full-conflict batch → `busy`=0, all `bank_en`=0, `rdata`=0 from cycle 3; no `done`. A fresh no-conflict batch afterwards completes in 3 cycles.
- **Back-to-back:** assert `start` again in the `done` cycle → second batch `bank_en` in the next cycle; both `done` pulses present with correct data.
